// File: rtl/shmcp_n_if.sv
// Host-facing channels of the compute core: instruction push, data-in and data-out.
// No latency of its own; bundles valid/ready pairs only.
// Backpressure is carried by instr_ready, din_ready and dout_ready.
interface shmcp_n_if #(
    parameter int DW = 4
);
    logic          load;
    logic [7:0]    instr;
    logic          instr_ready;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    modport master (
        output load, instr, din, din_valid, dout_ready,
        input  instr_ready, din_ready, dout, dout_valid
    );

    modport slave (
        input  load, instr, din, din_valid, dout_ready,
        output instr_ready, din_ready, dout, dout_valid
    );
endinterface

// File: rtl/shmcp_n.sv
// Generic synchronous FIFO with occupancy count.
// Latency: one cycle from push to the entry being visible at the head.
// Backpressure: push_rdy low at full; a pop in the same cycle does not free a slot for the push.
module shmcp_n_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    output logic                     push_rdy,
    output logic                     pop_vld,
    input  logic                     pop_rdy,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (count < FULL);
    assign pop_vld  = (count != '0);
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_rdy && pop_vld;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Microcoded compute core: instruction FIFO feeding a FETCH/DECODE/EXEC sequencer over 4 registers.
// Latency: ALU ops write back 3 cycles after leaving IDLE/EXEC; LDI/OUT add handshake wait cycles.
// Backpressure: stalls in WAIT_IN until din_valid and in WAIT_OUT until dout_ready; instr_ready tracks FIFO space.
module shmcp_n #(
    parameter int DW     = 4,
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      state,
    shmcp_n_if.slave                  io,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      busy,
    output logic                      zf,
    output logic                      cf,
    output logic                      err
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WAIT_IN,
        WAIT_OUT,
        HALT
    } fsm_t;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_OUT = 4'h2;
    localparam logic [3:0] OP_HLT = 4'hE;
    localparam logic [3:0] OP_ILL = 4'hF;

    fsm_t          fsm;
    logic [7:0]    ir;
    logic [DW-1:0] regs [4];
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [DW-1:0] dout_q;
    logic          dout_valid_q;
    logic          din_ready_q;

    logic [3:0]    opcode;
    logic [1:0]    ra;
    logic [1:0]    rb;
    logic          fifo_nempty;
    logic [7:0]    fifo_head;

    logic [DW-1:0] alu_res;
    logic          alu_cf;
    logic          alu_wr;

    assign opcode = ir[7:4];
    assign ra     = ir[3:2];
    assign rb     = ir[1:0];

    assign io.dout       = dout_q;
    assign io.dout_valid = dout_valid_q;
    assign io.din_ready  = din_ready_q;

    shmcp_n_fifo #(
        .W     (8),
        .DEPTH (QDEPTH)
    ) u_iq (
        .clk      (clk),
        .rst      (rst),
        .push_vld (io.load),
        .push_dat (io.instr),
        .push_rdy (io.instr_ready),
        .pop_vld  (fifo_nempty),
        .pop_rdy  (fsm == FETCH),
        .pop_dat  (fifo_head),
        .count    (q_count)
    );

    // Operands come from the DECODE latches so ra==rb sees one consistent value.
    always_comb begin
        alu_res = opa;
        alu_cf  = cf;
        alu_wr  = 1'b0;
        case (opcode)
            4'h3: begin
                alu_res = opb;
                alu_wr  = 1'b1;
            end
            4'h4: begin
                {alu_cf, alu_res} = {1'b0, opa} + {1'b0, opb};
                alu_wr            = 1'b1;
            end
            4'h5: begin
                {alu_cf, alu_res} = {1'b0, opa} - {1'b0, opb};
                alu_wr            = 1'b1;
            end
            4'h6: begin
                alu_res = opa & opb;
                alu_wr  = 1'b1;
            end
            4'h7: begin
                alu_res = opa | opb;
                alu_wr  = 1'b1;
            end
            4'h8: begin
                alu_res = opa ^ opb;
                alu_wr  = 1'b1;
            end
            4'h9: begin
                alu_res = ~opa;
                alu_wr  = 1'b1;
            end
            4'hA: begin
                alu_cf  = opa[DW-1];
                alu_res = {opa[DW-2:0], 1'b0};
                alu_wr  = 1'b1;
            end
            4'hB: begin
                alu_cf  = opa[0];
                alu_res = {1'b0, opa[DW-1:1]};
                alu_wr  = 1'b1;
            end
            4'hC: begin
                alu_cf  = &opa;
                alu_res = opa + DW'(1);
                alu_wr  = 1'b1;
            end
            4'hD: begin
                alu_cf  = ~|opa;
                alu_res = opa - DW'(1);
                alu_wr  = 1'b1;
            end
            default: begin
                alu_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm          <= IDLE;
            ir           <= '0;
            opa          <= '0;
            opb          <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
            zf           <= 1'b0;
            cf           <= 1'b0;
            err          <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (state && fifo_nempty) begin
                        fsm  <= FETCH;
                        busy <= 1'b1;
                    end
                end
                FETCH: begin
                    ir  <= fifo_head;
                    fsm <= DECODE;
                end
                DECODE: begin
                    opa <= regs[ra];
                    opb <= regs[rb];
                    if (opcode == OP_LDI) begin
                        fsm         <= WAIT_IN;
                        din_ready_q <= 1'b1;
                    end else if (opcode == OP_OUT) begin
                        fsm          <= WAIT_OUT;
                        dout_q       <= regs[ra];
                        dout_valid_q <= 1'b1;
                    end else begin
                        fsm <= EXEC;
                    end
                end
                WAIT_IN: begin
                    if (io.din_valid) begin
                        regs[ra]    <= io.din;
                        din_ready_q <= 1'b0;
                        fsm         <= EXEC;
                    end
                end
                WAIT_OUT: begin
                    if (io.dout_ready) begin
                        dout_valid_q <= 1'b0;
                        fsm          <= EXEC;
                    end
                end
                EXEC: begin
                    if (alu_wr) begin
                        regs[ra] <= alu_res;
                        cf       <= alu_cf;
                        zf       <= (alu_res == '0);
                    end
                    if (opcode == OP_ILL) begin
                        err <= 1'b1;
                    end
                    if (opcode == OP_HLT) begin
                        fsm <= HALT;
                    end else if (state && fifo_nempty) begin
                        fsm <= FETCH;
                    end else begin
                        fsm  <= IDLE;
                        busy <= 1'b0;
                    end
                end
                HALT: begin
                    if (!state) begin
                        fsm  <= IDLE;
                        busy <= 1'b0;
                    end
                end
                default: begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shmcp_n.sv
// Directed bench for shmcp_n: a DW=4 core for queue/handshake/halt/reset sequences
// and a DW=8 core driven from a table of single-op programs.
module tb_shmcp_n;
    logic       clk = 1'b0;
    logic       rst;
    logic       state4, state8;
    logic [2:0] q_count4, q_count8;
    logic       busy4, zf4, cf4, err4;
    logic       busy8, zf8, cf8, err8;

    shmcp_n_if #(.DW(4)) if4 ();
    shmcp_n_if #(.DW(8)) if8 ();

    shmcp_n #(.DW(4), .QDEPTH(4)) u4 (
        .clk(clk), .rst(rst), .state(state4), .io(if4),
        .q_count(q_count4), .busy(busy4), .zf(zf4), .cf(cf4), .err(err4)
    );

    shmcp_n #(.DW(8), .QDEPTH(4)) u8 (
        .clk(clk), .rst(rst), .state(state8), .io(if8),
        .q_count(q_count8), .busy(busy8), .zf(zf8), .cf(cf8), .err(err8)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [3:0] din_q4[$];
    logic [3:0] dout_got4[$];
    logic [7:0] din_q8[$];
    logic [7:0] dout_got8[$];
    bit         hold_out4 = 1'b0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cf;
        logic       zf;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle; the host side of the din/dout channels is serviced right after the falling edge.
    task automatic tick();
        @(negedge clk);
        if (if4.din_valid) begin
            if (!if4.din_ready) if4.din_valid = 1'b0;
        end else if (if4.din_ready && din_q4.size() != 0) begin
            if4.din       = din_q4.pop_front();
            if4.din_valid = 1'b1;
        end
        if (if4.dout_ready) begin
            if (!if4.dout_valid) if4.dout_ready = 1'b0;
        end else if (if4.dout_valid && !hold_out4) begin
            dout_got4.push_back(if4.dout);
            if4.dout_ready = 1'b1;
        end
        if (if8.din_valid) begin
            if (!if8.din_ready) if8.din_valid = 1'b0;
        end else if (if8.din_ready && din_q8.size() != 0) begin
            if8.din       = din_q8.pop_front();
            if8.din_valid = 1'b1;
        end
        if (if8.dout_ready) begin
            if (!if8.dout_valid) if8.dout_ready = 1'b0;
        end else if (if8.dout_valid) begin
            dout_got8.push_back(if8.dout);
            if8.dout_ready = 1'b1;
        end
    endtask

    task automatic push4(input logic [7:0] w);
        if4.load  = 1'b1;
        if4.instr = w;
        tick();
        if4.load  = 1'b0;
    endtask

    task automatic push8(input logic [7:0] w);
        if8.load  = 1'b1;
        if8.instr = w;
        tick();
        if8.load  = 1'b0;
    endtask

    task automatic wait_idle4(input string name);
        int n = 0;
        tick();
        tick();
        while ((busy4 || q_count4 != 0) && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, {31'b0, (busy4 || q_count4 != 0)}, 32'd0);
    endtask

    task automatic run8(input string name);
        int n = 0;
        state8 = 1'b1;
        tick();
        tick();
        while ((busy8 || q_count8 != 0) && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, {31'b0, (busy8 || q_count8 != 0)}, 32'd0);
        state8 = 1'b0;
    endtask

    function automatic logic [7:0] first8();
        return (dout_got8.size() != 0) ? dout_got8[0] : 8'hxx;
    endfunction

    function automatic logic [3:0] first4();
        return (dout_got4.size() != 0) ? dout_got4[0] : 4'hx;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] s[15];
        logic [3:0] model_r;
        int n;

        // op, a, b, result, cf, zf  (program: LDI R1,a; LDI R2,b; op R1,R2; OUT R1)
        vecs[0]  = '{4'h4, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
        vecs[1]  = '{4'h4, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[2]  = '{4'h6, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0};
        vecs[3]  = '{4'h5, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
        vecs[4]  = '{4'h5, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0};
        vecs[5]  = '{4'h7, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};
        vecs[6]  = '{4'h8, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1};
        vecs[7]  = '{4'h9, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0};
        vecs[8]  = '{4'hA, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0};
        vecs[9]  = '{4'h3, 8'h11, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[10] = '{4'hB, 8'h03, 8'h00, 8'h01, 1'b1, 1'b0};
        vecs[11] = '{4'hC, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[12] = '{4'hC, 8'h41, 8'h00, 8'h42, 1'b0, 1'b0};
        vecs[13] = '{4'hD, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
        vecs[14] = '{4'h0, 8'h33, 8'h00, 8'h33, 1'b1, 1'b0};

        // INC R0 / SHL R0 stream for the wraparound run
        s = '{8'hC0, 8'hA0, 8'hC0, 8'hC0, 8'hA0, 8'hC0, 8'hA0, 8'hA0,
              8'hC0, 8'hC0, 8'hC0, 8'hA0, 8'hC0, 8'hA0, 8'hC0};

        rst = 1'b0;
        state4 = 1'b0;
        state8 = 1'b0;
        if4.load = 1'b0; if4.instr = '0; if4.din = '0; if4.din_valid = 1'b0; if4.dout_ready = 1'b0;
        if8.load = 1'b0; if8.instr = '0; if8.din = '0; if8.din_valid = 1'b0; if8.dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();

        chk("rst_q4", q_count4, 0);
        chk("rst_irdy4", if4.instr_ready, 1);
        chk("rst_busy4", busy4, 0);
        chk("rst_dinrdy4", if4.din_ready, 0);
        chk("rst_dvld4", if4.dout_valid, 0);
        chk("rst_dout4", if4.dout, 0);
        chk("rst_zf4", zf4, 0);
        chk("rst_cf4", cf4, 0);
        chk("rst_err4", err4, 0);
        chk("rst_q8", q_count8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_err8", err8, 0);

        // Fill while stopped; the fifth push must be refused.
        push4(8'h10);
        push4(8'h14);
        push4(8'h41);
        push4(8'h20);
        push4(8'hF0);
        chk("full_q", q_count4, 4);
        chk("full_irdy", if4.instr_ready, 0);
        chk("full_busy", busy4, 0);

        din_q4.push_back(4'd9);
        din_q4.push_back(4'd8);
        dout_got4.delete();
        state4 = 1'b1;
        tick();
        // FETCH pops while full: the push alongside it is still refused.
        if4.load  = 1'b1;
        if4.instr = 8'hF0;
        tick();
        if4.load  = 1'b0;
        chk("full_pop_q", q_count4, 3);
        wait_idle4("progA");
        chk("progA_nout", dout_got4.size(), 1);
        chk("progA_dout", first4(), 4'h1);
        chk("progA_cf", cf4, 1);
        chk("progA_zf", zf4, 0);
        chk("progA_err", err4, 0);

        // OUT stall with dout_ready held low
        hold_out4 = 1'b1;
        dout_got4.delete();
        push4(8'h24);
        n = 0;
        while (!if4.dout_valid && n < 20) begin
            tick();
            n++;
        end
        chk("stall_seen", if4.dout_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("stall%0d_vld", i), if4.dout_valid, 1);
            chk($sformatf("stall%0d_dout", i), if4.dout, 4'h8);
            chk($sformatf("stall%0d_busy", i), busy4, 1);
        end
        hold_out4 = 1'b0;
        tick();
        tick();
        chk("stall_drop", if4.dout_valid, 0);
        chk("stall_keep", if4.dout, 4'h8);
        wait_idle4("stall");
        chk("stall_nout", dout_got4.size(), 1);

        // Illegal opcode then HLT with work still queued
        state4 = 1'b0;
        push4(8'hF0);
        push4(8'hE0);
        push4(8'hC0);
        push4(8'h20);
        chk("hlt_q0", q_count4, 4);
        state4 = 1'b1;
        repeat (15) tick();
        chk("hlt_err", err4, 1);
        chk("hlt_busy", busy4, 1);
        chk("hlt_q", q_count4, 2);
        state4 = 1'b0;
        tick();
        tick();
        chk("hlt_rel_busy", busy4, 0);
        chk("hlt_rel_q", q_count4, 2);
        dout_got4.delete();
        state4 = 1'b1;
        wait_idle4("hlt");
        chk("hlt_dout", first4(), 4'h2);
        chk("hlt_zf", zf4, 0);
        chk("hlt_err_sticky", err4, 1);

        // Reset while an LDI sits in WAIT_IN
        din_q4.delete();
        push4(8'h1C);
        n = 0;
        while (!if4.din_ready && n < 20) begin
            tick();
            n++;
        end
        chk("wi_dinrdy", if4.din_ready, 1);
        chk("wi_busy", busy4, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", busy4, 0);
        chk("arst_dinrdy", if4.din_ready, 0);
        chk("arst_err", err4, 0);
        chk("arst_q", q_count4, 0);
        chk("arst_irdy", if4.instr_ready, 1);
        chk("arst_dout", if4.dout, 0);
        chk("arst_dvld", if4.dout_valid, 0);
        chk("arst_cf", cf4, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) tick();
        chk("post_dinrdy", if4.din_ready, 0);
        chk("post_busy", busy4, 0);
        dout_got4.delete();
        push4(8'h2C);
        wait_idle4("post");
        chk("post_r3", first4(), 4'h0);

        // Push during every FETCH for three full pointer laps
        state4 = 1'b0;
        push4(s[0]);
        push4(s[1]);
        push4(s[2]);
        chk("wrap_q0", q_count4, 3);
        state4 = 1'b1;
        tick();
        for (int k = 3; k < 15; k++) begin
            if4.load  = 1'b1;
            if4.instr = s[k];
            tick();
            if4.load  = 1'b0;
            chk($sformatf("wrap%0d_q", k), q_count4, 3);
            tick();
            tick();
        end
        dout_got4.delete();
        push4(8'h20);
        wait_idle4("wrap");
        model_r = 4'h0;
        for (int k = 0; k < 15; k++) begin
            model_r = (s[k][7:4] == 4'hC) ? model_r + 4'h1 : {model_r[2:0], 1'b0};
        end
        chk("wrap_r0", first4(), model_r);

        // Table of single-op programs on the 8-bit core
        for (int i = 0; i < 15; i++) begin
            din_q8.delete();
            dout_got8.delete();
            din_q8.push_back(vecs[i].a);
            din_q8.push_back(vecs[i].b);
            push8(8'h14);
            push8(8'h18);
            push8({vecs[i].op, 4'b0110});
            push8(8'h24);
            run8($sformatf("v%0d", i));
            chk($sformatf("v%0d_dout", i), first8(), vecs[i].res);
            chk($sformatf("v%0d_cf", i), cf8, vecs[i].cf);
            chk($sformatf("v%0d_zf", i), zf8, vecs[i].zf);
        end

        // 8-bit shift/decrement/self-subtract sequence
        din_q8.delete();
        dout_got8.delete();
        din_q8.push_back(8'h80);
        push8(8'h18);
        push8(8'hA8);
        push8(8'h28);
        run8("shl");
        chk("shl_dout", first8(), 8'h00);
        chk("shl_cf", cf8, 1);
        chk("shl_zf", zf8, 1);
        dout_got8.delete();
        push8(8'hD8);
        push8(8'h28);
        run8("dec");
        chk("dec_dout", first8(), 8'hFF);
        chk("dec_cf", cf8, 1);
        chk("dec_zf", zf8, 0);
        dout_got8.delete();
        din_q8.push_back(8'h5A);
        push8(8'h1C);
        push8(8'h5F);
        push8(8'h2C);
        run8("sub33");
        chk("sub33_dout", first8(), 8'h00);
        chk("sub33_zf", zf8, 1);
        chk("sub33_cf", cf8, 0);
        chk("err8_clear", err8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/shmcp_n.md
Name: shmcp_n

Overview:
- Parametrised successor of the 4-bit hierarchical microcode processor top.
- Data width and instruction-queue depth are generic.
- The shared tristate bus is replaced by separate valid/ready input and output data channels.
- A FIFO decouples instruction loading from execution, and a multi-cycle control FSM sequences a 4-entry register file, ALU and flags.
- Sits at SoC level as a standalone compute core fed by a host loader.

Parameters:
- DW, 4, data/register width in bits (≥2).
- QDEPTH, 4, instruction FIFO depth (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low: 0 clears all state immediately.
- state  in  1  1 = run (execute queued instructions), 0 = stop after current instruction.
- load  in  1  instruction push request.
- instr  in  8  instruction word, pushed when load && instr_ready.
- instr_ready  out  1  FIFO not full.
- q_count  out  $clog2(QDEPTH)+1  FIFO occupancy.
- din  in  DW  input data for LDI.
- din_valid  in  1  din holds valid data.
- din_ready  out  1  core accepts din this cycle.
- dout  out  DW  output data from OUT.
- dout_valid  out  1  dout holds valid data.
- dout_ready  in  1  consumer accepts dout.
- busy  out  1  FSM not in IDLE.
- zf, cf  out  1 each  zero flag and carry flag.
- err  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset: FIFO empty, R0–R3=0, IR=0, zf=cf=0, err=0, dout=0, dout_valid=0, din_ready=0, busy=0, FSM=IDLE. Reset mid-instruction abandons that instruction.
- Instruction format: [7:4] opcode, [3:2] ra, [1:0] rb.
- FIFO push:
  - Push occurs when load && instr_ready; pushes are allowed in any FSM state and for either value of `state`.
  - instr_ready = (count < QDEPTH), computed from the registered count.
  - At full, a push is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo QDEPTH.
- FSM states: IDLE, FETCH, DECODE, EXEC, WAIT_IN, WAIT_OUT, HALT.
  - IDLE -> FETCH when state=1 and FIFO non-empty.
  - FETCH: pop FIFO head into IR (1 cycle).
  - DECODE: read Rra and Rrb into operand latches (1 cycle).
  - EXEC: writeback of register and flags; then go to FETCH if state=1 and FIFO non-empty, else IDLE.
  - ALU instructions take 3 cycles from leaving IDLE/EXEC to writeback.
- Opcodes:
  - 0 NOP.
  - 1 LDI: DECODE -> WAIT_IN. din_ready=1 only in WAIT_IN. On din_valid, Rra<=din and go to EXEC. Flags unchanged.
  - 2 OUT: DECODE -> WAIT_OUT. dout<=Rra and dout_valid=1 on entry. Hold both until dout_ready, then drop dout_valid and go to EXEC. dout retains its last value afterwards.
  - 3 MOV: Rra<=Rrb.
  - 4 ADD: {cf,Rra}<=Rra+Rrb, computed DW+1 wide.
  - 5 SUB: Rra<=Rra-Rrb; cf=1 on borrow (Rra<Rrb unsigned).
  - 6 AND, 7 OR, 8 XOR: Rra<=Rra op Rrb; cf unchanged.
  - 9 NOT: Rra<=~Rra.
  - A SHL: cf<=Rra[DW-1], Rra<=Rra<<1.
  - B SHR: cf<=Rra[0], Rra<=Rra>>1 with zero fill.
  - C INC and D DEC: wrap modulo 2^DW; cf set on wrap.
  - E HLT: EXEC -> HALT. Stay in HALT, with busy=1, until state=0, then go to IDLE.
  - F: illegal; executes as NOP and sets err=1. err clears only on reset.
- zf is updated by opcodes 3–D and equals (new Rra == 0).
- state=0 never aborts WAIT_IN or WAIT_OUT. The current instruction completes, then the FSM parks in IDLE.
- Same-register operands (ra==rb) use values latched in DECODE, e.g. SUB R1,R1 gives 0 with zf=1 and cf=0.

Test Plan:
- DW=4, state=0: push LDI R0, LDI R1, ADD R0,R1, OUT R0 -> FIFO holds 4 and instr_ready=0. Set state=1, din=9 then 8 -> dout=1 (4'h1), cf=1, zf=0.
- QDEPTH=4, push 5 instructions back-to-back with state=0 -> 5th refused, q_count=4. Pop and push in the same cycle once running -> count stays constant; verify pointer wraparound over 3 full cycles.
- OUT with dout_ready held low for 10 cycles -> dout_valid and dout stable throughout, busy=1. Assert dout_ready -> dout_valid drops the next cycle.
- DW=8: LDI R2=0x80, SHL R2 -> R2=0, cf=1, zf=1. DEC R2 -> 0xFF, cf=1. SUB R3,R3 -> 0, zf=1, cf=0.
- Opcode F, then HLT with more instructions queued -> err=1, FSM stays in HALT with the queue untouched. state=0 then state=1 -> remaining instructions execute.
- Deassert rst during WAIT_IN -> all outputs return to reset values asynchronously, FIFO empty, and the in-flight LDI is not completed.
